// File: rtl/ex_muldiv_sequencer.sv
// ex_muldiv_sequencer: multi-cycle MULT/MULTU/DIV/DIVU engine writing HI/LO, stalls upstream while busy
module ex_muldiv_sequencer #(
  parameter int DATA_W = 32,
  parameter int CNT_W  = 6
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [1:0]        op,
  input  logic [DATA_W-1:0] rs_val,
  input  logic [DATA_W-1:0] rt_val,
  input  logic              flush,
  output logic              busy,
  output logic              stall,
  output logic              done,
  output logic [DATA_W-1:0] hi,
  output logic [DATA_W-1:0] lo
);
  typedef enum logic [2:0] {IDLE, PREP, ITER, FIX, DONE} state_t;
  state_t state, state_n;
  logic [1:0]          op_q;
  logic [DATA_W-1:0]   a_q, b_q;
  logic [2*DATA_W-1:0] acc;
  logic [CNT_W-1:0]    cnt;
  logic                neg_q, neg_r;
  logic                sgn, sa, sb, mul, dz;
  logic [DATA_W-1:0]   mag_a, mag_b;
  logic [DATA_W:0]     sum;
  logic                ge;
  logic [DATA_W-1:0]   rem_n;
  logic [2*DATA_W-1:0] fix_p;
  logic [DATA_W-1:0]   fix_q, fix_r;
  assign mul   = ~op_q[1];
  assign sgn   = ~op_q[0];
  assign sa    = sgn & a_q[DATA_W-1];
  assign sb    = sgn & b_q[DATA_W-1];
  assign mag_a = sa ? -a_q : a_q;
  assign mag_b = sb ? -b_q : b_q;
  assign dz    = ~mul & (b_q == '0);
  assign sum   = {1'b0, acc[2*DATA_W-1:DATA_W]} + (acc[0] ? {1'b0, b_q} : '0);
  // acc holds {rem, quo}; the shifted remainder needs one extra bit for the compare
  assign ge    = acc[2*DATA_W-1:DATA_W-1] >= {1'b0, b_q};
  assign rem_n = ge ? acc[2*DATA_W-2:DATA_W-1] - b_q : acc[2*DATA_W-2:DATA_W-1];
  assign fix_p = neg_q ? -acc : acc;
  assign fix_q = neg_q ? -acc[DATA_W-1:0] : acc[DATA_W-1:0];
  assign fix_r = neg_r ? -acc[2*DATA_W-1:DATA_W] : acc[2*DATA_W-1:DATA_W];
  assign busy  = (state == PREP) | (state == ITER) | (state == FIX);
  assign stall = busy | (start & (state == IDLE));
  assign done  = state == DONE;
  always_comb begin
    state_n = state;
    case (state)
      IDLE:    state_n = start ? PREP : IDLE;
      PREP:    state_n = dz ? FIX : ITER;
      ITER:    state_n = (cnt == CNT_W'(1)) ? FIX : ITER;
      FIX:     state_n = DONE;
      default: state_n = IDLE;
    endcase
    if (flush && state != IDLE) state_n = IDLE;
  end
  always_ff @(posedge clk)
    if (rst) state <= IDLE;
    else state <= state_n;
  always_ff @(posedge clk) begin
    if (rst) begin
      op_q  <= '0;
      a_q   <= '0;
      b_q   <= '0;
      acc   <= '0;
      cnt   <= '0;
      neg_q <= 1'b0;
      neg_r <= 1'b0;
      hi    <= '0;
      lo    <= '0;
    end else begin
      case (state)
        IDLE: if (start) begin
          op_q <= op;
          a_q  <= rs_val;
          b_q  <= rt_val;
        end
        PREP: begin
          cnt   <= CNT_W'(DATA_W);
          b_q   <= mag_b;
          acc   <= dz ? {a_q, {DATA_W{1'b1}}} : {{DATA_W{1'b0}}, mag_a};
          neg_q <= ~dz & (sa ^ sb);
          neg_r <= ~dz & sa;
        end
        ITER: begin
          cnt <= cnt - CNT_W'(1);
          acc <= mul ? {sum, acc[DATA_W-1:1]} : {rem_n, acc[DATA_W-2:0], ge};
        end
        FIX: if (!flush) begin
          hi <= mul ? fix_p[2*DATA_W-1:DATA_W] : fix_r;
          lo <= mul ? fix_p[DATA_W-1:0] : fix_q;
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_ex_muldiv_sequencer.sv
// tb_ex_muldiv_sequencer: directed vector table plus multi-cycle corner sequences
module tb_ex_muldiv_sequencer;
  logic        clk = 0, rst = 1, start = 0, flush = 0;
  logic [1:0]  op = 0;
  logic [31:0] rs_val = 0, rt_val = 0;
  logic        busy, stall, done;
  logic [31:0] hi, lo;
  int n_vec = 0, n_err = 0;

  ex_muldiv_sequencer #(.DATA_W(32), .CNT_W(6)) dut (
    .clk(clk), .rst(rst), .start(start), .op(op), .rs_val(rs_val), .rt_val(rt_val),
    .flush(flush), .busy(busy), .stall(stall), .done(done), .hi(hi), .lo(lo)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [1:0]  op;
    logic [31:0] a, b, hi, lo;
    int          lat;
  } vec_t;
  vec_t tbl[12];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic run_op(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                        output logic [31:0] rh, output logic [31:0] rl, output int lat);
    tick();
    op = o; rs_val = a; rt_val = b; start = 1;
    #1 chk("stall_on_start", {31'b0, stall}, 32'd1);
    lat = -1;
    for (int c = 1; c <= 100; c++) begin
      tick();
      start = 0;
      if (done) begin
        lat = c;
        break;
      end
    end
    rh = hi; rl = lo;
  endtask

  logic [31:0] rh, rl;
  int lat;
  bit ok;

  initial begin
    tbl[0]  = '{2'd1, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, 35};
    tbl[1]  = '{2'd0, 32'hFFFFFFFD, 32'h00000007, 32'hFFFFFFFF, 32'hFFFFFFEB, 35};
    tbl[2]  = '{2'd2, 32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF, 32'hFFFFFFFD, 35};
    tbl[3]  = '{2'd3, 32'd100,      32'd0,        32'd100,      32'hFFFFFFFF, 3};
    tbl[4]  = '{2'd0, 32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000, 35};
    tbl[5]  = '{2'd2, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000, 35};
    tbl[6]  = '{2'd2, 32'd7,        32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD, 35};
    tbl[7]  = '{2'd2, 32'hFFFFFFFB, 32'd0,        32'hFFFFFFFB, 32'hFFFFFFFF, 3};
    tbl[8]  = '{2'd3, 32'hFFFFFFFF, 32'd10,       32'd5,        32'h19999999, 35};
    tbl[9]  = '{2'd1, 32'h12345678, 32'd0,        32'd0,        32'd0,        35};
    tbl[10] = '{2'd0, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'd0,        32'd1,        35};
    tbl[11] = '{2'd3, 32'd9,        32'd4,        32'd1,        32'd2,        35};

    tick(); tick();
    rst = 0;
    #1;
    chk("reset_hi", hi, 0);
    chk("reset_lo", lo, 0);
    chk("reset_busy_done_stall", {29'b0, busy, done, stall}, 0);

    foreach (tbl[i]) begin
      run_op(tbl[i].op, tbl[i].a, tbl[i].b, rh, rl, lat);
      chk($sformatf("v%0d_hi", i), rh, tbl[i].hi);
      chk($sformatf("v%0d_lo", i), rl, tbl[i].lo);
      chk($sformatf("v%0d_lat", i), lat, tbl[i].lat);
    end

    // divide by zero: stall low in DONE, done is a single pulse, stall stays low
    run_op(2'd3, 32'd100, 32'd0, rh, rl, lat);
    chk("dz_lat", lat, 3);
    chk("dz_stall_done", {31'b0, stall}, 0);
    tick();
    chk("dz_done_pulse", {30'b0, done, stall}, 0);

    // flush in ITER cycle 10; hi/lo keep 100 / all-ones from the last op
    tick();
    op = 2'd1; rs_val = 5; rt_val = 6; start = 1;
    tick();
    start = 0;
    for (int c = 2; c <= 11; c++) tick();
    chk("flush_busy_before", {31'b0, busy}, 1);
    flush = 1;
    tick();
    flush = 0;
    #1;
    chk("flush_idle", {30'b0, busy, stall}, 0);
    ok = 1;
    for (int c = 0; c < 40; c++) begin
      tick();
      if (done || busy) ok = 0;
    end
    chk("flush_no_done", {31'b0, ok}, 1);
    chk("flush_hi_kept", hi, 32'd100);
    chk("flush_lo_kept", lo, 32'hFFFFFFFF);

    // back-to-back with start held through DONE
    tick();
    op = 2'd1; rs_val = 3; rt_val = 4; start = 1;
    ok = 1;
    lat = -1;
    rh = 0;
    for (int c = 1; c <= 100; c++) begin
      tick();
      if (c == 1) begin
        op = 2'd3; rs_val = 100; rt_val = 7;
      end
      if (done && c < 40) begin
        chk("b2b_first_lat", c, 35);
        chk("b2b_first_lo", lo, 32'd12);
        chk("b2b_first_hi", hi, 32'd0);
        rh = 1;
      end
      if (done && c >= 40) begin
        lat = c;
        start = 0;
        break;
      end
      #1;
      if (!done && !stall) ok = 0;
      if (done && stall) ok = 0;
    end
    chk("b2b_first_seen", rh, 1);
    chk("b2b_second_lat", lat, 71);
    chk("b2b_second_lo", lo, 32'd14);
    chk("b2b_second_hi", hi, 32'd2);
    chk("b2b_stall_profile", {31'b0, ok}, 1);

    // reset mid-ITER clears hi/lo
    tick();
    op = 2'd1; rs_val = 5; rt_val = 6; start = 1;
    tick();
    start = 0;
    for (int c = 2; c <= 15; c++) tick();
    rst = 1;
    tick();
    rst = 0;
    #1;
    chk("rst_mid_hi", hi, 0);
    chk("rst_mid_lo", lo, 0);
    chk("rst_mid_busy", {30'b0, busy, stall}, 0);
    run_op(2'd3, 32'd9, 32'd4, rh, rl, lat);
    chk("after_rst_lo", rl, 32'd2);
    chk("after_rst_hi", rh, 32'd1);
    chk("after_rst_lat", lat, 35);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
